// File: rtl/transport_rcv.sv
// Telephony transport receive: decodes header, packs byte pairs into typed 16-bit words,
// buffers them in a word FIFO and hands one word per cycle to the session layer when it is not busy.
module transport_rcv #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rcvSignal,
  input  logic [7:0]  packetIn,
  input  logic        sessionBusy,
  output logic [1:0]  sendingToSession,
  output logic [15:0] data,
  output logic        dafuq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, HI, LO, DROP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  pkt_type, pkt_type_nxt;
  logic [7:0]  hi_byte, hi_byte_nxt;
  logic        push, proto_err;

  logic [17:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, wr_en, overflow;
  logic [17:0] rd_entry;

  always_comb begin
    state_nxt    = state;
    pkt_type_nxt = pkt_type;
    hi_byte_nxt  = hi_byte;
    push         = 1'b0;
    proto_err    = 1'b0;
    case (state)
      IDLE: begin
        if (rcvSignal) begin
          if (packetIn[7:6] == 2'b10 || packetIn[7:6] == 2'b01) begin
            pkt_type_nxt = packetIn[7:6];
            state_nxt    = HI;
          end else begin
            proto_err = 1'b1;
            state_nxt = DROP;
          end
        end
      end
      HI: begin
        if (rcvSignal) begin
          hi_byte_nxt = packetIn;
          state_nxt   = LO;
        end else begin
          state_nxt = IDLE;
        end
      end
      LO: begin
        if (rcvSignal) begin
          push      = 1'b1;
          state_nxt = HI;
        end else begin
          // odd-length packet: the dangling high byte is discarded
          proto_err   = 1'b1;
          hi_byte_nxt = 8'h00;
          state_nxt   = IDLE;
        end
      end
      DROP: begin
        if (!rcvSignal) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pkt_type <= 2'b00;
      hi_byte  <= 8'h00;
    end else begin
      state    <= state_nxt;
      pkt_type <= pkt_type_nxt;
      hi_byte  <= hi_byte_nxt;
    end
  end

  // extra pointer bit distinguishes full from empty
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = !sessionBusy && !empty;
  assign wr_en    = push && (!full || pop);
  assign overflow = push && full && !pop;
  assign rd_entry = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {pkt_type, hi_byte, packetIn};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      sendingToSession <= 2'b00;
      data             <= 16'h0000;
      dafuq            <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr           <= rd_ptr + PTR_ONE;
        sendingToSession <= rd_entry[17:16];
        data             <= rd_entry[15:0];
      end else begin
        sendingToSession <= 2'b00;
      end
      if (proto_err || overflow) dafuq <= 1'b1;
    end
  end

endmodule

// File: tb/tb_transport_rcv.sv
// Directed and randomized bench for transport_rcv against a packet-level reference model.
module tb_transport_rcv;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        rcvSignal;
  logic [7:0]  packetIn;
  logic        sessionBusy;
  logic [1:0]  sendingToSession;
  logic [15:0] data;
  logic        dafuq;

  transport_rcv #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rcvSignal(rcvSignal), .packetIn(packetIn),
    .sessionBusy(sessionBusy), .sendingToSession(sendingToSession),
    .data(data), .dafuq(dafuq)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [7:0]  pkt_q[$];
  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];
  int          obs_cyc[$];
  int          byte_edge[$];
  logic        err_model = 1'b0;
  logic        rand_busy = 1'b0;
  logic        bad_type = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sendingToSession != 2'b00) begin
      obs_q.push_back({sendingToSession, data});
      obs_cyc.push_back(cyc);
    end
    if (sendingToSession == 2'b11) bad_type = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packet-level model: header type, byte pairs become words, odd tail or bad header is an error.
  task automatic model_pkt();
    logic [1:0] t;
    t = pkt_q[0][7:6];
    if (t == 2'b00 || t == 2'b11) begin
      err_model = 1'b1;
    end else begin
      for (int k = 1; k + 1 < pkt_q.size(); k += 2)
        exp_q.push_back({t, pkt_q[k], pkt_q[k+1]});
      if (((pkt_q.size() - 1) % 2) != 0) err_model = 1'b1;
    end
  endtask

  task automatic send_pkt();
    byte_edge.delete();
    for (int i = 0; i < pkt_q.size(); i++) begin
      rcvSignal = 1'b1;
      packetIn  = pkt_q[i];
      if (rand_busy) sessionBusy = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      byte_edge.push_back(cyc);
    end
    rcvSignal = 1'b0;
    packetIn  = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_word%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    err_model = 1'b0;
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; rcvSignal = 1'b0; packetIn = 8'h00; sessionBusy = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_type", sendingToSession, 2'b00);
    check("rst_data", data, 16'h0000);
    check("rst_dafuq", dafuq, 1'b0);
    reset = 1'b0;

    // audio packet, latency and pulse spacing
    pkt_q = '{8'h80, 8'h12, 8'h34, 8'h56, 8'h78};
    model_pkt();
    send_pkt();
    repeat (4) @(posedge clk); #1;
    if (obs_cyc.size() >= 2) begin
      check("audio_lat0", obs_cyc[0], byte_edge[2] + 1);
      check("audio_lat1", obs_cyc[1], byte_edge[4] + 1);
    end
    check_stream("audio");
    check("audio_dafuq", dafuq, err_model);

    // control packet
    pkt_q = '{8'h40, 8'hAB, 8'hCD};
    model_pkt();
    send_pkt();
    repeat (4) @(posedge clk); #1;
    check_stream("ctrl");
    check("ctrl_dafuq", dafuq, err_model);

    // backpressure and overflow: 20 words into a 16-deep FIFO
    do_reset();
    sessionBusy = 1'b1;
    pkt_q = '{8'h80};
    for (int b = 0; b < 40; b++) pkt_q.push_back(8'(b));
    model_pkt();
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    err_model = 1'b1;
    for (int i = 0; i < pkt_q.size(); i++) begin
      rcvSignal = 1'b1;
      packetIn  = pkt_q[i];
      @(posedge clk); #1;
      if (i == 32) check("ovf_16th_dafuq", dafuq, 1'b0);
      if (i == 34) check("ovf_17th_dafuq", dafuq, 1'b1);
    end
    rcvSignal = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("ovf_busy_quiet", obs_q.size(), 0);
    sessionBusy = 1'b0;
    repeat (DEPTH + 4) @(posedge clk); #1;
    if (obs_cyc.size() == DEPTH)
      check("ovf_consecutive", obs_cyc[DEPTH-1], obs_cyc[0] + DEPTH - 1);
    check_stream("ovf");
    check("ovf_dafuq", dafuq, err_model);

    // invalid header
    do_reset();
    pkt_q = '{8'h00, 8'h11, 8'h22};
    model_pkt();
    send_pkt();
    repeat (4) @(posedge clk); #1;
    check_stream("badhdr");
    check("badhdr_dafuq", dafuq, err_model);

    // odd-length packet
    do_reset();
    pkt_q = '{8'h80, 8'h11, 8'h22, 8'h33};
    model_pkt();
    send_pkt();
    repeat (4) @(posedge clk); #1;
    check_stream("odd");
    check("odd_dafuq", dafuq, err_model);

    // reset mid-packet with FIFO non-empty, dafuq set and data non-zero
    do_reset();
    pkt_q = '{8'hC0, 8'h11};
    model_pkt();
    send_pkt();
    pkt_q = '{8'h40, 8'hAB, 8'hCD};
    model_pkt();
    send_pkt();
    repeat (3) @(posedge clk); #1;
    check_stream("pre_rst");
    sessionBusy = 1'b1;
    pkt_q = '{8'h80, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send_pkt();
    rcvSignal = 1'b1; packetIn = 8'h80;
    @(posedge clk); #1;
    packetIn = 8'h55;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("midrst_type", sendingToSession, 2'b00);
    check("midrst_data", data, 16'h0000);
    check("midrst_dafuq", dafuq, 1'b0);
    sessionBusy = 1'b0;
    packetIn = 8'h80;
    @(posedge clk); #1;
    reset = 1'b0;
    err_model = 1'b0;
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    pkt_q = '{8'h80, 8'h9A, 8'hBC};
    model_pkt();
    send_pkt();
    repeat (DEPTH) @(posedge clk); #1;
    check_stream("post_rst");
    check("post_rst_dafuq", dafuq, err_model);

    // randomized packets with random backpressure, drained between packets
    do_reset();
    for (int p = 0; p < 30; p++) begin
      int r;
      int len;
      logic [7:0] h;
      r = $urandom_range(0, 9);
      h = 8'($urandom);
      h[7:6] = (r < 4) ? 2'b10 : (r < 8) ? 2'b01 : (r == 8) ? 2'b00 : 2'b11;
      len = $urandom_range(0, 12);
      pkt_q = '{h};
      for (int b = 0; b < len; b++) pkt_q.push_back(8'($urandom));
      model_pkt();
      rand_busy = 1'b1;
      send_pkt();
      rand_busy = 1'b0;
      sessionBusy = 1'b0;
      repeat (12) @(posedge clk); #1;
      check_stream($sformatf("rnd%0d", p));
      check($sformatf("rnd%0d_dafuq", p), dafuq, err_model);
    end

    check("never_type_11", bad_type, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
